// File: rtl/demux_l2_1a4_pkg.sv
// Shared lane/word constants for the 4:1 serial lane mux/demux pair.
package demux_l2_1a4_pkg;

    localparam int NUM_LANES = 4;
    localparam int WORD_W    = 9;
    localparam int VALID_BIT = WORD_W - 1;
    localparam int CNT_W     = $clog2(NUM_LANES);

    localparam logic [CNT_W-1:0] LAST_LANE = CNT_W'(NUM_LANES - 1);

    typedef logic [WORD_W-1:0] word_t;
    typedef logic [CNT_W-1:0]  lane_t;

endpackage

// File: rtl/demux_lane_cnt.sv
// Frame position counter: wraps mod NUM_LANES, sync forces the next position to lane 1.
module demux_lane_cnt
    import demux_l2_1a4_pkg::*;
(
    input  logic             clk4f,
    input  logic             reset_L,
    input  logic             sync,
    output logic [CNT_W-1:0] lane_cnt,
    output logic             wrap
);

    // The sync word itself is lane 0, so the next word is lane 1.
    always_ff @(posedge clk4f or negedge reset_L) begin
        if (!reset_L)
            lane_cnt <= '0;
        else if (sync)
            lane_cnt <= CNT_W'(1);
        else
            lane_cnt <= lane_cnt + CNT_W'(1);
    end

    assign wrap = (lane_cnt == LAST_LANE);

endmodule

// File: rtl/demux_l2_1a4.sv
// Serial-to-parallel lane rebuild: collects four words per frame and presents
// them together on the lane-3 edge.
module demux_l2_1a4
    import demux_l2_1a4_pkg::*;
(
    input  logic              clk4f,
    input  logic              reset_L,
    input  logic [WORD_W-1:0] data_in,
    input  logic              sync,
    output logic [WORD_W-1:0] data0,
    output logic [WORD_W-1:0] data1,
    output logic [WORD_W-1:0] data2,
    output logic [WORD_W-1:0] data3,
    output logic [3:0]        valid_mask,
    output logic              frame_done,
    output logic              align_err
);

    lane_t lane_cnt;
    logic  wrap;
    word_t cap0, cap1, cap2;

    demux_lane_cnt u_lane_cnt (
        .clk4f    (clk4f),
        .reset_L  (reset_L),
        .sync     (sync),
        .lane_cnt (lane_cnt),
        .wrap     (wrap)
    );

    always_ff @(posedge clk4f or negedge reset_L) begin
        if (!reset_L) begin
            cap0       <= '0;
            cap1       <= '0;
            cap2       <= '0;
            data0      <= '0;
            data1      <= '0;
            data2      <= '0;
            data3      <= '0;
            valid_mask <= '0;
            frame_done <= 1'b0;
            align_err  <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            align_err  <= 1'b0;
            if (sync) begin
                // Realign: drop any partial frame, outputs keep the last full one.
                cap0      <= data_in;
                cap1      <= '0;
                cap2      <= '0;
                align_err <= (lane_cnt != '0);
            end else if (wrap) begin
                // Lane 3 goes straight to the output on its own sampling edge.
                data0      <= cap0;
                data1      <= cap1;
                data2      <= cap2;
                data3      <= data_in;
                valid_mask <= {data_in[VALID_BIT], cap2[VALID_BIT],
                               cap1[VALID_BIT], cap0[VALID_BIT]};
                frame_done <= 1'b1;
            end else begin
                case (lane_cnt)
                    2'd0:    cap0 <= data_in;
                    2'd1:    cap1 <= data_in;
                    default: cap2 <= data_in;
                endcase
            end
        end
    end

endmodule
